// File: rtl/seg7_capture.sv
// seg7_capture: readback monitor for a multiplexed, active-low 7-segment
// display bus. Samples segment and digit-select pins, waits for a stable
// window, then recovers each digit's hex value, dp state and valid/blank
// status. Illegal segment patterns and multi-digit selects set a sticky error.
module seg7_capture #(
   parameter int NDIG   = 4,
   parameter int STABLE = 3
) (
   input  logic                CLK,
   input  logic                nRST,
   input  logic [7:0]          nSEG,
   input  logic [NDIG-1:0]     nDIGSEL,
   input  logic                CLR,
   output logic [4*NDIG-1:0]   DOUT,
   output logic [NDIG-1:0]     DDOT,
   output logic [NDIG-1:0]     DVALID,
   output logic [NDIG-1:0]     DBLANK,
   output logic                UPD,
   output logic [2:0]          UIDX,
   output logic                ERR
);

   localparam int              SW       = NDIG + 8;
   localparam logic [3:0]      CNT_MAX  = 4'(STABLE);
   localparam logic [3:0]      CAP_AT   = 4'(STABLE - 2);
   localparam logic [NDIG-1:0] SEL_ONE  = NDIG'(1);
   localparam logic [6:0]      PAT_BLANK = 7'h7F;

   // Map a 7-bit active-low pattern (g..a) to {hit, value}; hit=0 if no hex glyph.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h40:   res = {1'b1, 4'h0};
         7'h79:   res = {1'b1, 4'h1};
         7'h24:   res = {1'b1, 4'h2};
         7'h30:   res = {1'b1, 4'h3};
         7'h19:   res = {1'b1, 4'h4};
         7'h12:   res = {1'b1, 4'h5};
         7'h02:   res = {1'b1, 4'h6};
         7'h78:   res = {1'b1, 4'h7};
         7'h00:   res = {1'b1, 4'h8};
         7'h10:   res = {1'b1, 4'h9};
         7'h08:   res = {1'b1, 4'hA};
         7'h03:   res = {1'b1, 4'hB};
         7'h46:   res = {1'b1, 4'hC};
         7'h21:   res = {1'b1, 4'hD};
         7'h06:   res = {1'b1, 4'hE};
         7'h0E:   res = {1'b1, 4'hF};
         default: res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   logic [SW-1:0]     samp_r;
   logic [SW-1:0]     prev_r;
   logic [3:0]        cnt_r;
   logic [3:0]        cnt_nxt_s;
   logic              cap_s;

   logic [NDIG-1:0]   sel_low_s;
   logic              any_sel_s;
   logic              one_sel_s;
   int                idx_s;
   logic [7:0]        seg_s;
   logic [4:0]        dec_s;

   logic [4*NDIG-1:0] dout_r,   dout_nxt_s;
   logic [NDIG-1:0]   ddot_r,   ddot_nxt_s;
   logic [NDIG-1:0]   dvalid_r, dvalid_nxt_s;
   logic [NDIG-1:0]   dblank_r, dblank_nxt_s;
   logic              upd_r,    upd_nxt_s;
   logic [2:0]        uidx_r,   uidx_nxt_s;
   logic              err_r,    err_nxt_s;

   // Stability counter: restart on any change of the sampled bus, else count up and saturate.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (samp_r != prev_r) begin
         cnt_nxt_s = 4'd0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_nxt_s = cnt_r;
      end else begin
         cnt_nxt_s = cnt_r + 4'd1;
      end
      cap_s = (samp_r == prev_r) && (cnt_r == CAP_AT);
   end

   // Select legality and addressed-digit index from the stable sample.
   always_comb begin
      seg_s     = samp_r[SW-1:NDIG];
      sel_low_s = ~samp_r[NDIG-1:0];
      any_sel_s = |sel_low_s;
      one_sel_s = any_sel_s && ((sel_low_s & (sel_low_s - SEL_ONE)) == {NDIG{1'b0}});
      dec_s     = seg_decode(seg_s[6:0]);
      idx_s     = 0;
      for (int i = 0; i < NDIG; i++) begin
         if (sel_low_s[i]) begin
            idx_s = i;
         end else begin
            idx_s = idx_s;
         end
      end
   end

   // Next-state of the per-digit results, update strobe and sticky error.
   always_comb begin
      dout_nxt_s   = dout_r;
      ddot_nxt_s   = ddot_r;
      dblank_nxt_s = dblank_r;
      uidx_nxt_s   = uidx_r;
      upd_nxt_s    = 1'b0;
      if (CLR) begin
         err_nxt_s    = 1'b0;
         dvalid_nxt_s = {NDIG{1'b0}};
      end else begin
         err_nxt_s    = err_r;
         dvalid_nxt_s = dvalid_r;
      end
      if (cap_s) begin
         if (one_sel_s) begin
            upd_nxt_s          = 1'b1;
            uidx_nxt_s         = 3'(idx_s);
            ddot_nxt_s[idx_s]  = ~seg_s[7];
            if (dec_s[4]) begin
               dout_nxt_s[4*idx_s +: 4] = dec_s[3:0];
               dvalid_nxt_s[idx_s]      = 1'b1;
               dblank_nxt_s[idx_s]      = 1'b0;
            end else if (seg_s[6:0] == PAT_BLANK) begin
               dvalid_nxt_s[idx_s]      = 1'b0;
               dblank_nxt_s[idx_s]      = 1'b1;
            end else begin
               dvalid_nxt_s[idx_s]      = 1'b0;
               dblank_nxt_s[idx_s]      = 1'b0;
               err_nxt_s                = 1'b1;
            end
         end else if (any_sel_s) begin
            // Several digits driven at once: nothing trustworthy to record.
            err_nxt_s = 1'b1;
         end else begin
            // Idle bus between scans: nothing to capture.
            err_nxt_s = err_nxt_s;
         end
      end else begin
         upd_nxt_s = 1'b0;
      end
   end

   // Pin sampling, stability tracking and output registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         samp_r   <= {SW{1'b1}};
         prev_r   <= {SW{1'b0}};
         cnt_r    <= 4'd0;
         dout_r   <= {(4*NDIG){1'b0}};
         ddot_r   <= {NDIG{1'b0}};
         dvalid_r <= {NDIG{1'b0}};
         dblank_r <= {NDIG{1'b0}};
         upd_r    <= 1'b0;
         uidx_r   <= 3'd0;
         err_r    <= 1'b0;
      end else begin
         samp_r   <= {nSEG, nDIGSEL};
         prev_r   <= samp_r;
         cnt_r    <= cnt_nxt_s;
         dout_r   <= dout_nxt_s;
         ddot_r   <= ddot_nxt_s;
         dvalid_r <= dvalid_nxt_s;
         dblank_r <= dblank_nxt_s;
         upd_r    <= upd_nxt_s;
         uidx_r   <= uidx_nxt_s;
         err_r    <= err_nxt_s;
      end
   end

   assign DOUT   = dout_r;
   assign DDOT   = ddot_r;
   assign DVALID = dvalid_r;
   assign DBLANK = dblank_r;
   assign UPD    = upd_r;
   assign UIDX   = uidx_r;
   assign ERR    = err_r;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (NDIG=4, STABLE=3).
module tb_seg7_capture;

   logic        CLK;
   logic        nRST;
   logic [7:0]  nSEG;
   logic [3:0]  nDIGSEL;
   logic        CLR;
   logic [15:0] DOUT;
   logic [3:0]  DDOT;
   logic [3:0]  DVALID;
   logic [3:0]  DBLANK;
   logic        UPD;
   logic [2:0]  UIDX;
   logic        ERR;

   int checks;
   int errors;
   int upd_cnt;
   logic [2:0] last_uidx;

   seg7_capture #(.NDIG(4), .STABLE(3)) dut (
      .CLK(CLK), .nRST(nRST), .nSEG(nSEG), .nDIGSEL(nDIGSEL), .CLR(CLR),
      .DOUT(DOUT), .DDOT(DDOT), .DVALID(DVALID), .DBLANK(DBLANK),
      .UPD(UPD), .UIDX(UIDX), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One clock edge, then settle; tally update pulses seen.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (UPD) begin
         upd_cnt++;
         last_uidx = UIDX;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [7:0] scan_code [4];

   initial begin
      checks = 0; errors = 0; upd_cnt = 0; last_uidx = 3'd0;
      scan_code[0] = 8'hC0; scan_code[1] = 8'h92;
      scan_code[2] = 8'h88; scan_code[3] = 8'h8E;

      // Reset
      nRST = 1'b0; nSEG = 8'hFF; nDIGSEL = 4'hF; CLR = 1'b0;
      ticks(3);
      chk("rst_dout",   DOUT,   32'h0);
      chk("rst_dvalid", DVALID, 32'h0);
      chk("rst_err",    ERR,    32'h0);
      chk("rst_upd",    UPD,    32'h0);
      chk("rst_ddot",   DDOT,   32'h0);
      chk("rst_dblank", DBLANK, 32'h0);
      nRST = 1'b1; upd_cnt = 0;
      ticks(20);
      chk("idle_no_upd", upd_cnt, 32'd0);

      // Capture latency: digit 1 = '2'
      nDIGSEL = 4'b1101; nSEG = 8'hA4;
      ticks(3);
      chk("lat_no_upd_e3", UPD, 32'h0);
      tick();
      chk("lat_upd_e4",  UPD,       32'h1);
      chk("lat_uidx",    UIDX,      32'd1);
      chk("lat_dout1",   DOUT[7:4], 32'h2);
      chk("lat_dvalid",  DVALID,    32'b0010);
      chk("lat_ddot",    DDOT,      32'h0);
      upd_cnt = 0;
      ticks(50);
      chk("lat_no_recap", upd_cnt, 32'd0);

      // Glitch rejection, then '9' with dp on digit 3
      nDIGSEL = 4'b0111; nSEG = 8'h80;
      ticks(2);
      nSEG = 8'h10; upd_cnt = 0;
      ticks(3);
      chk("glitch_no_upd", upd_cnt, 32'd0);
      tick();
      chk("dp_upd",    UPD,         32'h1);
      chk("dp_uidx",   UIDX,        32'd3);
      chk("dp_dout3",  DOUT[15:12], 32'h9);
      chk("dp_ddot",   DDOT,        32'b1000);
      chk("dp_dvalid", DVALID,      32'b1010);

      // Full scan 0,5,A,F
      upd_cnt = 0;
      for (int d = 0; d < 4; d++) begin
         nDIGSEL = ~(4'b0001 << d); nSEG = scan_code[d];
         ticks(4);
         chk("scan_upd",  UPD,  32'h1);
         chk("scan_uidx", UIDX, d);
         ticks(4);
      end
      chk("scan_dout",   DOUT,    32'hFA50);
      chk("scan_dvalid", DVALID,  32'hF);
      chk("scan_ddot",   DDOT,    32'h0);
      chk("scan_npulse", upd_cnt, 32'd4);

      // Blank on digit 0
      nDIGSEL = 4'b1110; nSEG = 8'hFF;
      ticks(4);
      chk("blank_upd",    UPD,    32'h1);
      chk("blank_uidx",   UIDX,   32'd0);
      chk("blank_dblank", DBLANK, 32'b0001);
      chk("blank_dvalid", DVALID, 32'b1110);
      chk("blank_dout",   DOUT,   32'hFA50);
      chk("blank_err",    ERR,    32'h0);

      // Illegal pattern on digit 0
      nSEG = 8'hFE;
      ticks(4);
      chk("illeg_upd",    UPD,    32'h1);
      chk("illeg_err",    ERR,    32'h1);
      chk("illeg_dblank", DBLANK, 32'b0000);
      chk("illeg_dvalid", DVALID, 32'b1110);
      chk("illeg_dout",   DOUT,   32'hFA50);
      ticks(2);
      CLR = 1'b1; tick(); CLR = 1'b0;
      chk("clr_err",    ERR,    32'h0);
      chk("clr_dvalid", DVALID, 32'h0);
      chk("clr_dout",   DOUT,   32'hFA50);

      // Double select
      nDIGSEL = 4'b1100; nSEG = 8'hC0; upd_cnt = 0;
      ticks(8);
      chk("dbl_err",    ERR,     32'h1);
      chk("dbl_no_upd", upd_cnt, 32'd0);
      chk("dbl_dout",   DOUT,    32'hFA50);
      CLR = 1'b1; tick(); CLR = 1'b0;
      chk("dbl_clr_err", ERR, 32'h0);

      // CLR together with a valid capture of digit 2 = '1'
      nDIGSEL = 4'b1011; nSEG = 8'hF9;
      ticks(3);
      CLR = 1'b1; tick(); CLR = 1'b0;
      chk("clrcap_upd",    UPD,    32'h1);
      chk("clrcap_dvalid", DVALID, 32'b0100);
      chk("clrcap_dout",   DOUT,   32'hF150);

      // CLR together with an error-causing capture
      nDIGSEL = 4'b0011; nSEG = 8'hC0;
      ticks(3);
      CLR = 1'b1; tick(); CLR = 1'b0;
      chk("clrerr_err",    ERR,    32'h1);
      chk("clrerr_dvalid", DVALID, 32'h0);
      CLR = 1'b1; tick(); CLR = 1'b0;

      // Reset mid-window, then a full window after release
      nDIGSEL = 4'b0111; nSEG = 8'hA4;
      ticks(3);
      nRST = 1'b0;
      tick();
      chk("mid_rst_dout",   DOUT,   32'h0);
      chk("mid_rst_dvalid", DVALID, 32'h0);
      chk("mid_rst_ddot",   DDOT,   32'h0);
      chk("mid_rst_err",    ERR,    32'h0);
      nRST = 1'b1; upd_cnt = 0;
      ticks(3);
      chk("post_rst_wait", upd_cnt, 32'd0);
      tick();
      chk("post_rst_upd",    UPD,    32'h1);
      chk("post_rst_uidx",   UIDX,   32'd3);
      chk("post_rst_dout",   DOUT,   32'h2000);
      chk("post_rst_dvalid", DVALID, 32'b1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Receive-side counterpart of the team's 7-segment display path: watches the multiplexed active-low segment bus and the digit-select lines driven to the display.
- Recovers, per digit, the 4-bit hex value and the decimal-point state, plus valid/blank information.
- Used as an on-chip self-check and readback monitor for the stopwatch display chain.
- Filters scan-transition glitches with a stability counter and flags illegal patterns.

Parameters:
NDIG, 4, number of multiplexed digits (1..8)
STABLE, 3, consecutive identical samples required before capture (2..15)

Ports:
CLK  input  1  system clock, all logic on rising edge
nRST  input  1  asynchronous active-low reset
nSEG  input  8  active-low segment bus; bit7 = dp, bits6:0 = g,f,e,d,c,b,a
nDIGSEL  input  NDIG  active-low digit selects, one-hot-low when legal
CLR  input  1  synchronous clear of ERR and DVALID
DOUT  output  4*NDIG  recovered hex values; digit i at [4i+3:4i]
DDOT  output  NDIG  recovered decimal point per digit (1 = lit)
DVALID  output  NDIG  digit i holds a decoded hex value
DBLANK  output  NDIG  digit i last seen blank (all segments off)
UPD  output  1  one-cycle pulse on every capture
UIDX  output  3  index of the digit captured with UPD
ERR  output  1  sticky error flag

Behaviour:
- Clocking and reset:
  - One clock domain; inputs are synchronous to CLK.
  - Reset is asynchronous, active-low (nRST).
  - On nRST low, all outputs and internal registers are 0, except the internal sample register, which is all ones (idle bus).
- Sampling and stability counter:
  - {nSEG, nDIGSEL} is registered into S every cycle.
  - cnt clears to 0 when S differs from its previous value. Otherwise it increments and saturates at STABLE.
- Capture timing:
  - A capture occurs on the edge where cnt goes from STABLE-2 to STABLE-1.
  - Exactly one capture per stable window; no re-capture until S changes.
  - Outputs change STABLE+1 edges after the pins settle; with STABLE=3, 4 edges.
- Select legality at capture:
  - Exactly one nDIGSEL bit is low: digit i is addressed.
  - All nDIGSEL high: no capture, no UPD, no error.
  - More than one bit low: no digit update, ERR set, UPD not pulsed.
- Decoding, on the pattern P = nSEG[6:0], for the addressed digit i:
  - Digit codes, P with bit7 forced to 1, shown as hex:
    - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
    - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - P matches a code: DOUT[i] = value, DVALID[i]=1, DBLANK[i]=0.
  - P = 7F (blank): DVALID[i]=0, DBLANK[i]=1, DOUT[i] unchanged.
  - Any other P: DVALID[i]=0, DBLANK[i]=0, DOUT[i] unchanged, ERR set.
  - DDOT[i] = ~nSEG[7] on every capture of digit i, regardless of pattern.
  - UPD=1 and UIDX=i for one cycle on every capture of a single addressed digit, including blank and illegal patterns.
- CLR:
  - Clears ERR and all DVALID on the next edge; DOUT, DDOT and DBLANK are kept.
  - If CLR coincides with an error-causing capture, the capture's ERR set wins and ERR=1.
  - If CLR coincides with a valid capture, that digit's DVALID=1; all others are cleared.
- Asserting nRST mid-window aborts the pending capture. After release, a full STABLE window is required before any capture.
- A select index that is out of range cannot occur because nDIGSEL width equals NDIG.
- UIDX is zero-extended when NDIG is 4 or less.

Test Plan:
- Reset: hold nRST=0 -> DOUT=0, DVALID=0, ERR=0, UPD=0. Release with nDIGSEL all 1 -> no UPD for 20 cycles.
- Capture latency: STABLE=3, nDIGSEL=4'b1101, nSEG=8'hA4 stable -> exactly one UPD, 4 edges after settle, with UIDX=1; DOUT[7:4]=2, DVALID[1]=1, DDOT[1]=0. Held 50 cycles -> no second UPD.
- Glitch rejection and dp: pattern held 2 cycles then changed -> no capture. Then nSEG=8'h10 (9 with dp lit) on digit 3 -> DOUT[15:12]=9, DDOT[3]=1.
- Full scan: cycle digits 0..3 with 0,5,A,F, each held 8 cycles -> DOUT=16'hFA50, DVALID=4'hF, four UPD pulses with UIDX 0,1,2,3.
- Blank, illegal pattern and double select:
  - nSEG=8'hFF on digit 0 -> DBLANK[0]=1, DVALID[0]=0, DOUT[3:0] kept.
  - nSEG=8'hFE -> ERR=1.
  - nDIGSEL=4'b1100 -> ERR=1, no UPD.
  - CLR pulse -> ERR=0.
- Reset mid-window: assert nRST at cnt=1 -> all cleared. After release, the same stable pattern captures only after a full window.
